// File: rtl/obuf_drain.sv
// Output-buffer drain: reads bytes from shared memory through a req/gnt port
// and streams them to a valid/ready sink until len bytes, a NUL byte, or abort.
module obuf_drain #(
  parameter int unsigned   AW       = 17,
  parameter logic [AW-1:0] OBUF     = AW'(32'h1400),
  parameter bit            NUL_STOP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          base_sel,
  input  logic [AW-1:0] base,
  input  logic [15:0]   len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [15:0]   sent,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic [AW-1:0] mem_a,
  input  logic [7:0]    mem_di,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    RD   = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [15:0]   cnt;

  // Single registered FSM; done is raised on the edge that leaves FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent     <= 16'd0;
      mem_req  <= 1'b0;
      mem_a    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
      ptr      <= '0;
      cnt      <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sent <= 16'd0;
            if (len != 16'd0) begin
              ptr     <= base_sel ? base : OBUF;
              mem_a   <= base_sel ? base : OBUF;
              cnt     <= len;
              busy    <= 1'b1;
              mem_req <= 1'b1;
              state   <= ARB;
            end else begin
              state <= FIN;
            end
          end
        end

        ARB: begin
          if (abort) begin
            mem_req <= 1'b0;
            state   <= FIN;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RD;
          end
        end

        RD: begin
          if (abort) begin
            state <= FIN;
          end else begin
            tx_data <= mem_di;
            if (NUL_STOP && (mem_di == 8'h00)) begin
              state <= FIN;
            end else begin
              tx_valid <= 1'b1;
              state    <= SEND;
            end
          end
        end

        SEND: begin
          // A handshake in the abort cycle still counts the byte.
          if (tx_ready) begin
            tx_valid <= 1'b0;
            sent     <= sent + 16'd1;
            cnt      <= cnt - 16'd1;
            ptr      <= ptr + AW'(1);
            if (abort || (cnt == 16'd1)) begin
              state <= FIN;
            end else begin
              mem_req <= 1'b1;
              mem_a   <= ptr + AW'(1);
              state   <= ARB;
            end
          end else if (abort) begin
            tx_valid <= 1'b0;
            state    <= FIN;
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_req  <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/obuf_drain.md
Name: obuf_drain

Overview:
- Read-side counterpart of the dictionary/ROM loader: a byte-bus read master that drains the output buffer the eJ32 core fills.
- Streams each byte from memory to a console/UART sink over a valid/ready interface.
- Shares the byte memory with the core through a simple req/gnt arbiter port.
- Runs after the core idles, or between outer-interpreter passes, to emit OBUF contents.

Parameters:
AW, 17, byte address width of the memory bus
OBUF, 'h1400, default base address used when base_sel=0
NUL_STOP, 1, 1 = a 0x00 byte terminates the transfer and is not sent

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a drain; ignored while busy
base_sel  in  1  0 = start at OBUF, 1 = start at base
base  in  AW  start address when base_sel=1, sampled on start
len  in  16  maximum byte count, sampled on start
abort  in  1  terminate current drain
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer (normal, NUL or abort)
sent  out  16  bytes handed off in current/last transfer
mem_req  out  1  bus request
mem_gnt  in  1  bus grant, valid same cycle as mem_req
mem_a  out  AW  read address, valid while mem_req=1
mem_di  in  8  read data, valid the cycle after a granted request
tx_valid  out  1  byte available
tx_data  out  8  byte value
tx_ready  in  1  sink accepts byte

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, mem_req, tx_valid=0; mem_a, tx_data, sent=0; internal ptr/cnt=0.
- States: IDLE, ARB, RD, SEND, FIN.
- IDLE:
  - start with len!=0: ptr=(base_sel?base:OBUF), cnt=len, sent=0, busy=1, go ARB.
  - start with len==0: sent=0, go FIN; no bus request.
- ARB: mem_req=1, mem_a=ptr. If mem_gnt, go RD next edge; otherwise hold, with mem_a stable.
- RD: mem_req=0. Capture mem_di into tx_data.
  - NUL_STOP=1 and mem_di==0: go FIN, tx_valid stays 0.
  - Otherwise tx_valid=1 from next cycle, go SEND.
- SEND: tx_valid=1; tx_data stable until handshake.
  - On tx_valid&tx_ready: tx_valid=0, sent+=1, cnt-=1, ptr=ptr+1 (mod 2^AW, wraps silently).
  - Then go FIN if cnt reaches 0, else ARB.
- FIN: done=1 for exactly one cycle, busy=0, go IDLE. sent holds until the next start.
- Timing: minimum 3 cycles per byte (ARB with gnt, RD, SEND with ready). First mem_req rises the cycle after start.
- abort in any non-IDLE state:
  - Next edge goes to FIN; mem_req and tx_valid drop that edge; the pending byte is discarded and not counted.
  - abort coinciding with a tx handshake: the handshake counts (sent increments), then FIN.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: start wins.
- start while busy: ignored; base/len not resampled.
- mem_gnt while mem_req=0: ignored.
- tx_ready while tx_valid=0: ignored.
- Async reset mid-transfer: all state cleared, no done pulse.

Test Plan:
- Memory at 0x1400 = "ok\n" (6F 6B 0A) then 00; start base_sel=0 len=16, tx_ready=1, gnt=1 -> tx bytes 6F,6B,0A; done pulse; sent=3; NUL not sent; one byte per 3 cycles.
- base_sel=1 base=0x1FFFF len=2, bytes 41 at 0x1FFFF and 42 at 0x00000 -> tx 41 then 42, showing mem_a wraps to 0; sent=2.
- len=0 start -> done pulse 2 cycles after start; mem_req never asserted; sent=0.
- tx_ready held low 10 cycles with byte 55 pending -> tx_valid and tx_data=55 stable throughout; no new mem_req until handshake.
- mem_gnt low 5 cycles in ARB -> mem_req and mem_a held constant; after gnt, data captured the following cycle.
- abort during SEND of the 2nd byte (no ready) -> tx_valid drops next edge; done pulse; sent=1. Separately, assert rst mid-ARB -> mem_req=0 immediately, no done.
